bus_arb2: RTL and testbench

//  Two-master arbiter and sequencer for the register bus.
//  Two requesters share one bus_in/bus_out bus, for example the host command parser and the capture/DMA engine.

---
 rtl/bus_arb2.sv | 196 +++++++++++++++++++
 tb/tb_bus_arb2.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// bus_arb2: two-master round-robin arbiter and sequencer for the register bus.
// One transaction in flight; each access ends on the matching ack or on a timeout.
module bus_arb2 #(
  parameter int unsigned BUS_ADDR_WIDTH = 16,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned BUS_IN_WIDTH   = BUS_ADDR_WIDTH + BUS_DATA_WIDTH + 4,
  parameter int unsigned BUS_OUT_WIDTH  = BUS_DATA_WIDTH + 3,
  parameter int unsigned TIMEOUT        = 255,
  parameter logic [BUS_DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                      bus_clk,
  input  logic                      bus_reset_l,
  output logic [BUS_IN_WIDTH-1:0]   bus_in,
  input  logic [BUS_OUT_WIDTH-1:0]  bus_out,
  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
  input  logic [BUS_DATA_WIDTH-1:0] m0_wr_data,
  output logic                      m0_done,
  output logic [BUS_DATA_WIDTH-1:0] m0_rd_data,
  output logic                      m0_err,
  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
  input  logic [BUS_DATA_WIDTH-1:0] m1_wr_data,
  output logic                      m1_done,
  output logic [BUS_DATA_WIDTH-1:0] m1_rd_data,
  output logic                      m1_err,
  output logic                      irq
);

  localparam int unsigned AW = BUS_ADDR_WIDTH;
  localparam int unsigned DW = BUS_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;
  logic          irq_q;

  logic [DW-1:0] b_rdata;
  logic          b_rack;
  logic          b_wack;
  logic          b_irq;

  logic          pick;
  logic          ack;
  logic          tmo;
  logic          fin;
  logic          ferr;
  logic [DW-1:0] fdata;

  assign b_rdata = bus_out[DW+2:3];
  assign b_rack  = bus_out[2];
  assign b_wack  = bus_out[1];
  assign b_irq   = bus_out[0];

  assign bus_in = {bus_clk, bus_reset_l, addr_q, wd_q, we_q, re_q};

  assign m0_done    = done0_q;
  assign m0_rd_data = rd0_q;
  assign m0_err     = err0_q;
  assign m1_done    = done1_q;
  assign m1_rd_data = rd1_q;
  assign m1_err     = err1_q;
  assign irq        = irq_q;

  // On a tie the master that did not win last time gets the bus.
  assign pick = (m0_req && m1_req) ? ~last_q : m1_req;
  // Only the ack kind matching the strobe ends the access.
  assign ack  = we_q ? b_wack : b_rack;
  // This strobe cycle is the TIMEOUT-th one; an ack in the same cycle wins.
  assign tmo  = (TIMEOUT != 0) &&
                (({16'd0, cnt_q} + 32'd1) >= TIMEOUT);

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    re_d    = re_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = err0_q;
    err1_d  = err1_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    fin     = 1'b0;
    ferr    = 1'b0;
    fdata   = gnt_q ? rd1_q : rd0_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = S_ACCESS;
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? m1_we : m0_we;
          re_d    = ~(pick ? m1_we : m0_we);
          addr_d  = pick ? m1_addr : m0_addr;
          wd_d    = pick ? m1_wr_data : m0_wr_data;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        if (ack) begin
          fin = 1'b1;
          if (re_q) fdata = b_rdata;
        end else if (tmo) begin
          fin   = 1'b1;
          ferr  = 1'b1;
          fdata = TIMEOUT_DATA;
        end
        if (fin) begin
          state_d = S_DONE;
          we_d    = 1'b0;
          re_d    = 1'b0;
          if (gnt_q) begin
            done1_d = 1'b1;
            rd1_d   = fdata;
            err1_d  = ferr;
          end else begin
            done0_d = 1'b1;
            rd0_d   = fdata;
            err0_d  = ferr;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the strobe immediately.
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      irq_q   <= b_irq;
    end
  end

endmodule

// File: tb/tb_bus_arb2.sv
// tb_bus_arb2: directed and randomized checks of bus_arb2
// against a behavioural slave and a transaction-level reference.
module tb_bus_arb2;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int IW = AW + DW + 4;
  localparam int OW = DW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IW-1:0] bus_in;
  logic [OW-1:0] bus_out;

  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wd = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wd = '0;
  logic          m0_done, m0_err, m1_done, m1_err, irq;
  logic [DW-1:0] m0_rd, m1_rd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_arb2 #(.TIMEOUT(8)) dut (
    .bus_clk     (clk),
    .bus_reset_l (rst_n),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wr_data  (m0_wd),
    .m0_done     (m0_done),
    .m0_rd_data  (m0_rd),
    .m0_err      (m0_err),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wr_data  (m1_wd),
    .m1_done     (m1_done),
    .m1_rd_data  (m1_rd),
    .m1_err      (m1_err),
    .irq         (irq)
  );

  logic          b_clk, b_rst, b_we, b_re;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wd;
  assign {b_clk, b_rst, b_addr, b_wd, b_we, b_re} = bus_in;

  // behavioural slave: 256 words below 0x400, ack after dly wait cycles
  logic [31:0] mem  [0:255];
  logic [31:0] refm [0:255];
  int   dly = 0;
  int   scnt = 0;
  bit   noise = 1'b0;
  bit   wrong_en = 1'b0;
  bit   irq_s = 1'b0;
  logic mapped, hit;
  logic [7:0] sidx;

  assign mapped = b_addr < 16'h0400;
  assign sidx   = b_addr[9:2];
  assign hit    = (b_we | b_re) && mapped && (scnt == dly);
  assign bus_out = {mapped ? mem[sidx] : 32'h0,
                    (b_re & hit) | noise | (b_we & wrong_en),
                    (b_we & hit) | noise | (b_re & wrong_en),
                    irq_s};

  always @(posedge clk or negedge rst_n)
    if (!rst_n) scnt <= 0;
    else if ((b_we | b_re) && !hit) scnt <= scnt + 1;
    else scnt <= 0;

  always @(posedge clk)
    if (b_we && hit) mem[sidx] <= b_wd;

  bit fin0 = 1'b0;
  bit fin1 = 1'b0;
  bit mlast = 1'b1;
  logic [31:0] exp_rd [2];

  task automatic set_m(input int m, input logic rq, input logic we,
                       input logic [15:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = rq; m0_we = we; m0_addr = a; m0_wd = d;
    end else begin
      m1_req = rq; m1_we = we; m1_addr = a; m1_wd = d;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({b_we, b_re, b_addr, b_wd} !== '0) begin
      bad++; $display("FAIL reset_bus got=%h want=0", {b_we, b_re, b_addr, b_wd});
    end
    total++;
    if ({m0_done, m1_done, m0_err, m1_err, irq} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000",
                      {m0_done, m1_done, m0_err, m1_err, irq});
    end
    total++;
    if ({m0_rd, m1_rd} !== 64'h0) begin
      bad++; $display("FAIL reset_rd got=%h want=0", {m0_rd, m1_rd});
    end
    total++;
    if (b_rst !== 1'b0 || b_clk !== clk) begin
      bad++; $display("FAIL reset_pass got=%b%b want=0%b", b_rst, b_clk, clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (b_rst !== 1'b1) begin
      bad++; $display("FAIL reset_release got=%b want=1", b_rst);
    end
  endtask

  task automatic test_write();
    dly = 0;
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 16'h0010, 32'h12345678);
    refm[4] = 32'h12345678;
    @(negedge clk);
    total++;
    if ({b_we, b_re} !== 2'b10 || b_addr !== 16'h0010 ||
        b_wd !== 32'h12345678 || m0_done !== 1'b0) begin
      bad++; $display("FAIL wr_strobe got=%b%b %h %h d=%b want=10 0010 12345678 d=0",
                      b_we, b_re, b_addr, b_wd, m0_done);
    end
    @(negedge clk);
    total++;
    if (b_we !== 1'b0 || m0_done !== 1'b1 || m0_err !== 1'b0 || m1_done !== 1'b0) begin
      bad++; $display("FAIL wr_done got=we%b d%b e%b d1%b want=we0 d1 e0 d10",
                      b_we, m0_done, m0_err, m1_done);
    end
    set_m(0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    total++;
    if (m0_done !== 1'b0 || b_we !== 1'b0) begin
      bad++; $display("FAIL wr_pulse got=d%b we%b want=d0 we0", m0_done, b_we);
    end
  endtask

  task automatic test_read_delay();
    int nre;
    bit got;
    nre = 0;
    got = 1'b0;
    mem[8] = 32'hCAFEF00D;
    refm[8] = 32'hCAFEF00D;
    dly = 3;
    @(negedge clk);
    set_m(1, 1'b1, 1'b0, 16'h0020, 32'h0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b_re) nre++;
      if (m1_done) got = 1'b1;
    end
    set_m(1, 1'b0, 1'b0, 16'h0, 32'h0);
    total++;
    if (!got) begin
      bad++; $display("FAIL rd_done got=none want=m1_done");
    end
    total++;
    if (nre != 4) begin
      bad++; $display("FAIL rd_len got=%0d want=4", nre);
    end
    total++;
    if (m1_rd !== 32'hCAFEF00D || m1_err !== 1'b0) begin
      bad++; $display("FAIL rd_data got=%h e%b want=cafef00d e0", m1_rd, m1_err);
    end
  endtask

  task automatic test_alternate();
    int ord[$];
    int ovl;
    int g;
    ovl = 0;
    g = 0;
    dly = 0;
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 16'h0000, 32'h0);
    set_m(1, 1'b1, 1'b0, 16'h0004, 32'h0);
    while (ord.size() < 4 && g < 40) begin
      @(negedge clk);
      g++;
      if (b_we && b_re) ovl++;
      if (m0_done && m1_done) ovl++;
      if (m0_done) ord.push_back(0);
      if (m1_done) ord.push_back(1);
    end
    set_m(0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 16'h0, 32'h0);
    total++;
    if (ord.size() != 4) begin
      bad++; $display("FAIL alt_count got=%0d want=4", ord.size());
    end
    for (int i = 0; i < ord.size(); i++) begin
      total++;
      if (ord[i] != i % 2) begin
        bad++; $display("FAIL alt_order idx=%0d got=%0d want=%0d", i, ord[i], i % 2);
      end
    end
    total++;
    if (ovl != 0 || m0_rd !== refm[0] || m1_rd !== refm[1]) begin
      bad++; $display("FAIL alt_data got=ovl%0d %h %h want=ovl0 %h %h",
                      ovl, m0_rd, m1_rd, refm[0], refm[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int nre;
    bit got;
    nre = 0;
    got = 1'b0;
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 16'h0480, 32'h0);
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (b_re) nre++;
      if (m0_done) got = 1'b1;
    end
    set_m(0, 1'b0, 1'b0, 16'h0, 32'h0);
    total++;
    if (!got || nre != 8) begin
      bad++; $display("FAIL tmo_len got=%0d done=%b want=8 done=1", nre, got);
    end
    total++;
    if (m0_err !== 1'b1 || m0_rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL tmo_data got=e%b %h want=e1 deadbeef", m0_err, m0_rd);
    end
  endtask

  task automatic test_reset_mid();
    int nre;
    int nod;
    bit got;
    int at;
    nre = 0;
    nod = 0;
    got = 1'b0;
    at = 0;
    dly = 3;
    @(negedge clk);
    set_m(1, 1'b1, 1'b0, 16'h0020, 32'h0);
    for (int i = 0; i < 10 && nre < 2; i++) begin
      @(negedge clk);
      if (b_re) nre++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (b_re !== 1'b0 || b_we !== 1'b0) begin
      bad++; $display("FAIL rstmid_strobe got=%b%b want=00", b_we, b_re);
    end
    set_m(1, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      if (m0_done || m1_done) nod++;
    end
    total++;
    if (m1_rd !== 32'h0) begin
      bad++; $display("FAIL rstmid_rd got=%h want=0", m1_rd);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m0_done || m1_done || b_re || b_we) nod++;
    end
    total++;
    if (nod != 0) begin
      bad++; $display("FAIL rstmid_quiet got=%0d want=0", nod);
    end
    dly = 0;
    set_m(1, 1'b1, 1'b0, 16'h0020, 32'h0);
    for (int i = 1; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m1_done) begin
        got = 1'b1;
        at = i;
      end
    end
    set_m(1, 1'b0, 1'b0, 16'h0, 32'h0);
    total++;
    if (!got || at != 2 || m1_rd !== 32'hCAFEF00D || m1_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_fresh got=d%b at%0d %h e%b want=d1 at2 cafef00d e0",
                      got, at, m1_rd, m1_err);
    end
  endtask

  task automatic test_drop_mid();
    int ord[$];
    int g;
    g = 0;
    dly = 2;
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 16'h0000, 32'h0);
    @(negedge clk);
    total++;
    if (b_re !== 1'b1 || b_addr !== 16'h0000) begin
      bad++; $display("FAIL drop_grant got=re%b %h want=re1 0000", b_re, b_addr);
    end
    set_m(0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_m(1, 1'b1, 1'b0, 16'h0004, 32'h0);
    while (ord.size() < 2 && g < 40) begin
      @(negedge clk);
      g++;
      if (m0_done) begin
        ord.push_back(0);
        total++;
        if (m0_rd !== refm[0] || m0_err !== 1'b0) begin
          bad++; $display("FAIL drop_data got=%h e%b want=%h e0", m0_rd, m0_err, refm[0]);
        end
      end
      if (m1_done) begin
        ord.push_back(1);
        set_m(1, 1'b0, 1'b0, 16'h0, 32'h0);
      end
    end
    set_m(1, 1'b0, 1'b0, 16'h0, 32'h0);
    total++;
    if (ord.size() != 2 || ord[0] != 0 || ord[1] != 1) begin
      bad++; $display("FAIL drop_order got=n%0d want=0 then 1", ord.size());
    end
    @(negedge clk);
  endtask

  task automatic test_irq();
    bit prev;
    bit v;
    prev = 1'b0;
    noise = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (irq !== prev || m0_done || m1_done || b_we || b_re) begin
          bad++; $display("FAIL irq_idle got=irq%b d%b%b s%b%b want=irq%b d00 s00",
                          irq, m0_done, m1_done, b_we, b_re, prev);
        end
      end
      v = 1'($urandom);
      irq_s = v;
      prev = v;
    end
    noise = 1'b0;
    @(negedge clk);
    total++;
    if (irq !== prev) begin
      bad++; $display("FAIL irq_last got=%b want=%b", irq, prev);
    end
    irq_s = 1'b0;
  endtask

  task automatic drive(input int m);
    bit we;
    bit unm;
    bit got;
    int idx;
    logic [15:0] a;
    logic [31:0] d, rd, ew;
    logic er, ee;
    for (int n = 0; n < 15; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      #1;
      we  = 1'($urandom);
      unm = ($urandom % 10) == 0;
      idx = $urandom_range(0, 15);
      a   = unm ? 16'(16'h0400 + idx * 4) : 16'(idx * 4);
      d   = $urandom;
      set_m(m, 1'b1, we, a, d);
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (m == 0 ? m0_done : m1_done) got = 1'b1;
      end
      total++;
      if (!got) begin
        bad++; $display("FAIL rnd_wait m%0d got=no done want=done", m);
      end else begin
        rd = (m == 0) ? m0_rd : m1_rd;
        er = (m == 0) ? m0_err : m1_err;
        if (unm) begin
          ew = 32'hDEADBEEF; ee = 1'b1;
        end else if (!we) begin
          ew = refm[idx]; ee = 1'b0;
        end else begin
          ew = exp_rd[m]; ee = 1'b0;
          refm[idx] = d;
        end
        exp_rd[m] = ew;
        if (rd !== ew || er !== ee) begin
          bad++; $display("FAIL rnd_result m%0d a=%h got=%h e%b want=%h e%b",
                          m, a, rd, er, ew, ee);
        end
      end
      #1 set_m(m, 1'b0, 1'b0, 16'h0, 32'h0);
    end
    if (m == 0) fin0 = 1'b1;
    else fin1 = 1'b1;
  endtask

  task automatic monitor();
    int len;
    int elen;
    int g;
    bit act;
    bit cur;
    len = 0;
    elen = 0;
    g = 0;
    act = 1'b0;
    cur = 1'b0;
    while (!(fin0 && fin1) && g < 5000) begin
      @(negedge clk);
      g++;
      wrong_en = 1'($urandom);
      if (b_we || b_re) begin
        if (!act) begin
          act = 1'b1;
          len = 1;
          cur = (m0_req && m1_req) ? !mlast : m1_req;
          mlast = cur;
          elen = mapped ? dly + 1 : 8;
        end else begin
          len++;
        end
      end else if (!act) begin
        dly = $urandom_range(0, 4);
      end else begin
        act = 1'b0;
        total++;
        if (len != elen) begin
          bad++; $display("FAIL rnd_len got=%0d want=%0d", len, elen);
        end
        total++;
        if ((cur ? m1_done : m0_done) !== 1'b1) begin
          bad++; $display("FAIL rnd_grant got=d%b%b want=m%0d", m0_done, m1_done, cur);
        end
      end
    end
    wrong_en = 1'b0;
    total++;
    if (!(fin0 && fin1)) begin
      bad++; $display("FAIL rnd_end got=unfinished want=finished");
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    mlast = 1'b1;
    fork
      drive(0);
      drive(1);
      monitor();
    join
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = $urandom;
      refm[i] = mem[i];
    end
    test_reset();
    test_write();
    test_read_delay();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_drop_mid();
    test_irq();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
